// File: rtl/dma_copy_pkg.sv
// Shared types and constants for the dma_copy word-copy engine.
package dma_copy_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_RUN  = 2'd1,
        DMA_DONE = 2'd2
    } dma_state_e;

    localparam logic [3:0]  WSTRB_FULL = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/dma_fifo.sv
// Synchronous FIFO used as the read-to-write data buffer of dma_copy.
// Push and pop in the same cycle are always legal; when empty the pushed word bypasses to head.
module dma_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             bypass, do_push, do_pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign count  = count_q;
    assign head   = empty ? push_data : mem_q[rd_ptr_q];

    // A push/pop pair on an empty FIFO passes the word straight through without storing it.
    assign bypass  = empty && push && pop;
    assign do_push = push && (!full || pop) && !bypass;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dma_copy.sv
// Word-copy DMA initiator: reads len_words words from src_addr and writes them to dst_addr.
// Define DMA_IRQ_EN to add a sticky completion interrupt (irq, cleared by irq_clr).
module dma_copy
    import dma_copy_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             rready,
    input  logic             rvalid,
    output logic [31:0]      raddr,
    input  logic             rresp,
    input  logic [31:0]      rdata,
    output logic             wready,
    input  logic             wvalid,
    output logic [31:0]      waddr,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb
`ifdef DMA_IRQ_EN
    ,
    output logic             irq,
    input  logic             irq_clr
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    dma_state_e       state_q, state_d;
    logic [31:0]      raddr_q, raddr_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rd_issued_q, rd_issued_d;
    logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]    outst_q, outst_d;

    logic             fifo_push, fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [31:0]      fifo_head;
    logic [CW:0]      inflight;
    logic             rd_acc, wr_acc;

    dma_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (rdata),
        .pop       (wr_acc),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Buffered plus in-flight words may never exceed the FIFO, so responses always fit.
    assign inflight  = {1'b0, fifo_count} + {1'b0, outst_q};
    assign fifo_push = rresp && (outst_q != '0);
    assign rd_acc    = rready && rvalid;
    assign wr_acc    = wready && wvalid;

    always_comb begin
        rready = (state_q == DMA_RUN) && (rd_issued_q < len_q) && !fifo_full &&
                 (inflight < (CW+1)'(FIFO_DEPTH));
        wready = (state_q == DMA_RUN) && !fifo_empty;
        raddr  = raddr_q;
        waddr  = waddr_q;
        wdata  = wready ? fifo_head : 32'h0;
        wstrb  = wready ? WSTRB_FULL : 4'h0;
        busy   = (state_q != DMA_IDLE);
        done   = (state_q == DMA_DONE);
    end

    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        len_d       = len_q;
        rd_issued_d = rd_issued_q;
        wr_cnt_d    = wr_cnt_q;
        outst_d     = outst_q + CW'(rd_acc) - CW'(fifo_push);
        unique case (state_q)
            DMA_IDLE: begin
                if (start) begin
                    raddr_d     = src_addr;
                    waddr_d     = dst_addr;
                    len_d       = len_words;
                    rd_issued_d = '0;
                    wr_cnt_d    = '0;
                    state_d     = (len_words == '0) ? DMA_DONE : DMA_RUN;
                end
            end
            DMA_RUN: begin
                if (rd_acc) begin
                    raddr_d     = raddr_q + WORD_BYTES;
                    rd_issued_d = rd_issued_q + LEN_W'(1);
                end
                if (wr_acc) begin
                    waddr_d  = waddr_q + WORD_BYTES;
                    wr_cnt_d = wr_cnt_q + LEN_W'(1);
                    if (wr_cnt_q == len_q - LEN_W'(1)) state_d = DMA_DONE;
                end
            end
            DMA_DONE: state_d = DMA_IDLE;
            default:  state_d = DMA_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= DMA_IDLE;
            raddr_q     <= '0;
            waddr_q     <= '0;
            len_q       <= '0;
            rd_issued_q <= '0;
            wr_cnt_q    <= '0;
            outst_q     <= '0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            len_q       <= len_d;
            rd_issued_q <= rd_issued_d;
            wr_cnt_q    <= wr_cnt_d;
            outst_q     <= outst_d;
        end
    end

`ifdef DMA_IRQ_EN
    logic irq_q, irq_d;

    // Set on entry to DONE so irq rises together with done; set beats a simultaneous clear.
    always_comb begin
        irq_d = irq_q;
        if (state_d == DMA_DONE) irq_d = 1'b1;
        else if (irq_clr)        irq_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

endmodule

// File: doc/dma_copy.md
Name: dma_copy

Overview:
- Word-copy engine acting as initiator (master) on the codebase's simple peripheral bus: read channel rready/rvalid/raddr/rresp/rdata, write channel wready/wvalid/waddr/wdata/wstrb.
- Reads len_words 32-bit words from src_addr and writes them in order to dst_addr through a small internal FIFO.
- Sits between the core's control logic and memory-mapped targets, for example memory or clint-style peripherals.

Parameters:
- FIFO_DEPTH, 4, data buffer entries; power of two, minimum 2.
- LEN_W, 16, width of the transfer length in words.

Ports:
- clk  in  1  the single clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a transfer; ignored while busy.
- src_addr  in  32  source byte address, word aligned; sampled on accepted start.
- dst_addr  in  32  destination byte address, word aligned; sampled on accepted start.
- len_words  in  LEN_W  number of words to copy; sampled on accepted start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when a transfer completes.
- rready  out  1  read request valid.
- rvalid  in  1  target can accept a read request.
- raddr  out  32  read address.
- rresp  in  1  read data valid, returned in request order.
- rdata  in  32  read data.
- wready  out  1  write request valid.
- wvalid  in  1  target can accept a write.
- waddr  out  32  write address.
- wdata  out  32  write data.
- wstrb  out  4  byte strobes; always 4'hF when wready=1.
- irq  out  1  present only with DMA_IRQ_EN; see Optional Feature.
- irq_clr  in  1  present only with DMA_IRQ_EN; see Optional Feature.

Behaviour:
- Reset values: busy=0, done=0, rready=0, wready=0, raddr=0, waddr=0, wdata=0, wstrb=0, irq=0. FIFO is emptied and all counters are zeroed.
- Read handshake:
  - A read is accepted in a cycle where rready=1 and rvalid=1.
  - Once asserted, rready and raddr are held stable until accepted.
  - Data returns on a later cycle (latency ≥1) with rresp=1.
  - Each rresp pushes rdata into the FIFO.
- Write handshake:
  - A write is accepted in a cycle where wready=1 and wvalid=1.
  - Once asserted, wready, waddr and wdata are held stable until accepted.
- States:
  - IDLE: start with len_words≠0 goes to RUN and latches the addresses and length. start with len_words=0 goes to DONE with no bus activity.
  - RUN: reads and writes proceed concurrently. Goes to DONE in the cycle the last write is accepted.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - busy=1 in RUN and DONE.
- Read issue:
  - Allowed only while rd_issued < len and fifo_count + outstanding < FIFO_DEPTH, so the FIFO can never overflow.
  - outstanding increments on read accept and decrements on rresp.
  - A read accept and an rresp in the same cycle leave outstanding unchanged.
- Write issue: wready=1 whenever the FIFO is non-empty in RUN. wdata is the FIFO head.
- Address arithmetic: raddr and waddr advance by 4 per accepted transfer and wrap modulo 2^32 (0xFFFFFFFC is followed by 0x00000000).
- Simultaneous push and pop are legal, including when the FIFO is full or empty-with-bypass. Count stays unchanged; no data is lost or duplicated.
- rresp while outstanding=0 (for example a stray response after reset) is ignored and does not push.
- Reset mid-transfer: every output returns to its reset value immediately (asynchronous). Buffered data is discarded. No done pulse is generated.
- start while busy=1 is ignored and has no effect on any state.

Optional Feature:
- Macro: DMA_IRQ_EN.
- Defined:
  - irq is set in the DONE cycle and stays set until irq_clr=1.
  - If set and clear fall in the same cycle, set wins.
- Undefined: irq and irq_clr ports are absent; completion is signalled only by done.

Decomposition:
- Shared package:
  - State encoding constants: DMA_IDLE, DMA_RUN, DMA_DONE.
  - Full-word strobe constant WSTRB_FULL = 4'hF.
- Natural sub-module: dma_fifo.
  - Synchronous FIFO, DEPTH and WIDTH parameters.
  - Ports: push/pop, full/empty, count.
  - Same clock and reset as the parent.

Test Plan:
- src=0x100, dst=0x200, len=1, rvalid=wvalid=1, rresp one cycle after accept with rdata=0xDEADBEEF → single read at 0x100, then write 0x200/0xDEADBEEF/wstrb=4'hF, then done pulses once and busy drops.
- len=8, FIFO_DEPTH=4, wvalid=0 → exactly 4 reads accepted, then rready=0. Raise wvalid → 8 writes at dst..dst+0x1C with data in read order.
- len=0 → done one cycle after start, rready and wready never asserted.
- start pulsed again mid-transfer with different addresses → ignored; original 5-word copy completes unchanged.
- reset asserted after 3 writes of an 8-word copy → all outputs zero at once; a later stray rresp is ignored; a new 2-word copy completes correctly.
- src=0xFFFFFFFC, len=2 → raddr 0xFFFFFFFC then 0x00000000. With DMA_IRQ_EN, irq rises at done and clears on irq_clr.
